// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider with per-channel period ticks.
// Each channel divides clk by a runtime-loadable N >= 2. Its output is high
// for ceil(N/2) cycles and low for the rest. Divisor writes wait in a
// one-deep pending slot and take effect only when a new period starts.
module clock_divider_multi #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned COUNT_WIDTH = 8,
    parameter int unsigned DEFAULT_DIV = 6,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH-1:0]      en,
    input  logic                   sync,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CH_W-1:0]        cfg_ch,
    input  logic [COUNT_WIDTH-1:0] cfg_div,
    output logic                   cfg_err,
    output logic [NUM_CH-1:0]      clk_out,
    output logic [NUM_CH-1:0]      tick
);

    localparam logic [CH_W:0]        NumChW = (CH_W + 1)'(NUM_CH);
    localparam logic [COUNT_WIDTH-1:0] DefDiv = COUNT_WIDTH'(DEFAULT_DIV);

    // Reset: asserted asynchronously, released through two flops.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    // cnt_q is the phase currently shown on clk_out/tick while live_q is set.
    // arm_q delays a freshly enabled channel by one cycle before phase 0.
    logic [COUNT_WIDTH-1:0] cnt_q  [NUM_CH];
    logic [COUNT_WIDTH-1:0] cnt_d  [NUM_CH];
    logic [COUNT_WIDTH-1:0] div_q  [NUM_CH];
    logic [COUNT_WIDTH-1:0] div_d  [NUM_CH];
    logic [COUNT_WIDTH-1:0] pdiv_q [NUM_CH];
    logic [COUNT_WIDTH-1:0] pdiv_d [NUM_CH];
    logic [NUM_CH-1:0]      pend_q, pend_d;
    logic [NUM_CH-1:0]      arm_q;
    logic [NUM_CH-1:0]      live_q, live_d;
    logic [NUM_CH-1:0]      clk_out_q, clk_out_d;
    logic [NUM_CH-1:0]      tick_q, tick_d;
    logic                   err_q, err_d;

    logic ch_ok, div_ok, xfer, wr_ok;

    // Two-flop synchroniser for reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // Config handshake decode; out-of-range channels are always ready so the
    // bad write can be consumed and flagged.
    always_comb begin
        ch_ok     = ({1'b0, cfg_ch} < NumChW);
        div_ok    = (cfg_div >= COUNT_WIDTH'(2));
        cfg_ready = ch_ok ? ~pend_q[cfg_ch] : 1'b1;
        xfer      = cfg_valid & cfg_ready;
        wr_ok     = xfer & ch_ok & div_ok;
        err_d     = xfer & ~(ch_ok & div_ok);
    end

    // Per-channel next state: phase advance, period restart and divisor load.
    always_comb begin
        logic                 load;
        logic [COUNT_WIDTH:0] half;
        load      = 1'b0;
        half      = '0;
        cnt_d     = cnt_q;
        div_d     = div_q;
        pdiv_d    = pdiv_q;
        pend_d    = pend_q;
        live_d    = live_q;
        clk_out_d = '0;
        tick_d    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load = 1'b0;
            if (!en[i]) begin
                live_d[i] = 1'b0;
                cnt_d[i]  = '0;
                load      = pend_q[i];
            end else if (sync || (arm_q[i] && !live_q[i]) ||
                         (live_q[i] && (cnt_q[i] == div_q[i] - COUNT_WIDTH'(1)))) begin
                // New period: sync, first period after enable, or wrap.
                live_d[i] = 1'b1;
                cnt_d[i]  = '0;
                load      = pend_q[i];
            end else if (live_q[i]) begin
                cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
            end
            if (load) begin
                div_d[i]  = pdiv_q[i];
                pend_d[i] = 1'b0;
            end
            // A write only lands on a channel whose slot was empty, so it
            // never collides with the load above.
            if (wr_ok && (cfg_ch == CH_W'(i))) begin
                pend_d[i] = 1'b1;
                pdiv_d[i] = cfg_div;
            end
            half         = ({1'b0, div_d[i]} + (COUNT_WIDTH + 1)'(1)) >> 1;
            clk_out_d[i] = live_d[i] && ({1'b0, cnt_d[i]} < half);
            tick_d[i]    = live_d[i] && (cnt_d[i] == '0);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                div_q[i]  <= DefDiv;
                pdiv_q[i] <= DefDiv;
            end
            pend_q    <= '0;
            arm_q     <= '0;
            live_q    <= '0;
            clk_out_q <= '0;
            tick_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                div_q[i]  <= div_d[i];
                pdiv_q[i] <= pdiv_d[i];
            end
            pend_q    <= pend_d;
            arm_q     <= en;
            live_q    <= live_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            err_q     <= err_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign cfg_err = err_q;

endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
Multi-channel programmable clock-enable/divider generator, the next generation of the single fixed-ratio divider.
- NUM_CH independent channels, each dividing clk by a runtime-loadable integer N ≥ 2.
- Each channel produces a near-50% duty output plus a one-cycle period-start tick.
- Divisor updates are glitch-free, applied only at period boundaries.
- A global sync input phase-aligns all channels.
- Used to derive baud, PWM-base and LED-scan rates from the single system clock.

Parameters:
NUM_CH, 4, number of divider channels (1..16)
COUNT_WIDTH, 8, width of divisor and per-channel counter
DEFAULT_DIV, 6, divisor loaded into every channel at reset (2..2^COUNT_WIDTH-1)
CH_W, clog2(NUM_CH) min 1, width of channel select (derived, localparam)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
en  in  NUM_CH  per-channel enable
sync  in  1  one-cycle pulse, restarts all enabled channels at phase 0
cfg_valid  in  1  divisor write request
cfg_ready  out  1  write can be accepted
cfg_ch  in  CH_W  target channel
cfg_div  in  COUNT_WIDTH  new divisor N
cfg_err  out  1  one-cycle pulse: accepted write was rejected
clk_out  out  NUM_CH  divided outputs, registered
tick  out  NUM_CH  one-cycle pulse on first cycle of each period, registered

Behaviour:
- Reset (rst=0, async):
  - all counters 0; active divisor = DEFAULT_DIV; no pending update.
  - clk_out=0, tick=0, cfg_err=0, cfg_ready=1.
  - Deassertion is synchronised internally (2-flop) before logic leaves reset.
- Period: channel with active divisor N and H = ceil(N/2) (i.e. (N+1)>>1):
  - clk_out high for H cycles, then low for N-H cycles, repeating.
  - tick=1 exactly on the first high cycle of each period.
  - N=2 gives 1/1; N=5 gives 3/2; N=255 gives 128/127.
- Enable:
  - en[i] low: counter held at 0, clk_out[i]=0, tick[i]=0.
  - en[i] sampled high at edge k (previously low): first tick[i]/clk_out[i] high visible after edge k+1.
  - Dropping en[i] mid-period forces outputs low on the next edge; re-enabling restarts at phase 0.
- Counter: counts 0..N-1 and wraps. Wrap cycle = period boundary. Counter width COUNT_WIDTH; no overflow is possible because N ≤ 2^COUNT_WIDTH-1.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready at a rising edge.
  - Each channel has one pending-divisor slot.
  - cfg_ready = 0 iff the channel addressed by cfg_ch holds a pending update (combinational from cfg_ch and pending flags).
  - Pending value becomes active at the channel's next boundary: wrap or sync. While the channel is disabled, it becomes active on the next edge.
  - The running period is never shortened or stretched.
- Rejection:
  - cfg_div < 2 or cfg_ch ≥ NUM_CH → transfer consumed, cfg_err=1 for the following cycle, no state change.
- Sync:
  - On the edge after sync=1, every enabled channel loads its pending divisor if present, clears its counter, and starts a new period (tick=1).
  - sync overrides a coincident wrap; the two do not produce a double tick.
  - Write accepted in the same cycle as sync: becomes pending and applies at the following boundary, not this sync.
- Simultaneous write and boundary on the same channel: the value already pending applies at the boundary. A new write to that channel is blocked by cfg_ready=0.

Test Plan:
1. Reset, en=4'b1111, N=6 default → each clk_out: 3 high / 3 low; tick every 6 cycles; first tick one cycle after en sampled.
2. Mid-period (counter=2), write ch1 div=5 → ch1 finishes the 6-cycle period, then runs 3 high / 2 low with tick every 5; other channels unchanged.
3. Write div=2 then div=255 (COUNT_WIDTH=8) → 1/1 toggle, then 128 high / 127 low. While the second write is pending, cfg_ready=0 for that channel only.
4. cfg_div=1, then cfg_ch=NUM_CH with cfg_valid=1 → cfg_err pulses one cycle each; divisors and outputs unchanged.
5. ch0 N=4, ch2 N=6 running out of phase, pulse sync → both tick on the next cycle; ticks then coincide every 12 cycles. en[3]=0 stays low throughout.
6. Assert rst low mid-period, between clock edges → all outputs 0 immediately. After release, all channels resume at N=6 with phase 0.
